// File: rtl/vga_pkg.sv
// Shared VGA constants and the tile-map entry layout used by the fetch stage and vgaFSM.
package vga_pkg;
    localparam int H_ACTIVE   = 640;
    localparam int V_ACTIVE   = 480;
    localparam int TILE_SHIFT = 5;
    localparam int TILES_X    = 20;
    localparam int TILES_Y    = 15;

    typedef struct packed {
        logic [3:0] fg;
        logic [3:0] bg;
        logic [7:0] glyph;
    } tile_word_t;
endpackage

// File: rtl/vga_sync_delay.sv
// N-stage shift register for side-band video signals (bright, syncs, frame flag).
module vga_sync_delay #(
    parameter int           N       = 3,
    parameter int           W       = 4,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [N-1:0][W-1:0] pipe;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pipe <= {N{RST_VAL}};
        end else begin
            pipe[0] <= d;
            for (int i = 1; i < N; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign q = pipe[N-1];
endmodule

// File: rtl/vga_tile_fetch.sv
// Raster position -> scrolled tile-map BRAM address, with side-band re-timed so every
// output lands exactly three clocks after its input sample.
module vga_tile_fetch #(
    parameter int TILE_SHIFT = vga_pkg::TILE_SHIFT,
    parameter int TILES_X    = vga_pkg::TILES_X,
    parameter int TILES_Y    = vga_pkg::TILES_Y,
    parameter int H_ACTIVE   = vga_pkg::H_ACTIVE,
    parameter int V_ACTIVE   = vga_pkg::V_ACTIVE,
    parameter int BASE_ADDR  = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [9:0]            hCount,
    input  logic [9:0]            vCount,
    input  logic                  bright,
    input  logic                  hSync_in,
    input  logic                  vSync_in,
    input  logic [9:0]            scroll_x,
    input  logic [9:0]            scroll_y,
    input  logic [15:0]           q_b,
    output logic [9:0]            addr_b,
    output logic [15:0]           tile_word,
    output logic [TILE_SHIFT-1:0] px_x,
    output logic [TILE_SHIFT-1:0] px_y,
    output logic                  bright_out,
    output logic                  hSync_out,
    output logic                  vSync_out,
    output logic                  frame_start
);
    import vga_pkg::*;

    localparam int SPAN_X = TILES_X << TILE_SHIFT;
    localparam int SPAN_Y = TILES_Y << TILE_SHIFT;
    localparam int SBW    = 4 + 2*TILE_SHIFT;
    localparam int STAGES = 2;

    function automatic logic [9:0] wrap_scroll(input logic [9:0] s, input int span);
        return (s >= 10'(span)) ? s - 10'(span) : s;
    endfunction

    logic [9:0]  sx_l, sy_l, sx_eff, sy_eff, addr_nxt;
    logic [10:0] sx_sum, sy_sum, sx, sy;
    logic        origin, act, ok;
    logic [STAGES-1:0] vld_pipe;
    logic [SBW-1:0]    sb_d, sb_q;
    logic [TILE_SHIFT-1:0] px2, py2;
    logic        fs2, vs2, hs2, act2;
    tile_word_t  tw_q;

    // The origin pixel sees the freshly requested scroll, not the stale latch.
    assign origin = (hCount == 10'd0) && (vCount == 10'd0);
    assign sx_eff = origin ? wrap_scroll(scroll_x, SPAN_X) : sx_l;
    assign sy_eff = origin ? wrap_scroll(scroll_y, SPAN_Y) : sy_l;
    assign sx_sum = 11'(hCount) + 11'(sx_eff);
    assign sy_sum = 11'(vCount) + 11'(sy_eff);
    assign sx     = (sx_sum >= 11'(SPAN_X)) ? sx_sum - 11'(SPAN_X) : sx_sum;
    assign sy     = (sy_sum >= 11'(SPAN_Y)) ? sy_sum - 11'(SPAN_Y) : sy_sum;
    assign act    = bright && (hCount < 10'(H_ACTIVE)) && (vCount < 10'(V_ACTIVE));
    assign addr_nxt = 10'(BASE_ADDR + int'(sy >> TILE_SHIFT) * TILES_X + int'(sx >> TILE_SHIFT));

    assign sb_d = {sx[TILE_SHIFT-1:0], sy[TILE_SHIFT-1:0], origin, vSync_in, hSync_in, act};
    assign {px2, py2, fs2, vs2, hs2, act2} = sb_q;

    // S1/S2 side-band; syncs idle high so reset looks like sync-inactive.
    vga_sync_delay #(
        .N       (STAGES),
        .W       (SBW),
        .RST_VAL (SBW'(4'b0110))
    ) u_sb_dly (
        .clk   (clk),
        .reset (reset),
        .d     (sb_d),
        .q     (sb_q)
    );

    assign ok        = act2 && vld_pipe[STAGES-1];
    assign tile_word = tw_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sx_l        <= '0;
            sy_l        <= '0;
            addr_b      <= 10'(BASE_ADDR);
            vld_pipe    <= '0;
            tw_q        <= '0;
            px_x        <= '0;
            px_y        <= '0;
            bright_out  <= 1'b0;
            hSync_out   <= 1'b1;
            vSync_out   <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            if (origin) begin
                sx_l <= sx_eff;
                sy_l <= sy_eff;
            end
            if (act) addr_b <= addr_nxt;
            vld_pipe    <= {vld_pipe[STAGES-2:0], 1'b1};
            tw_q        <= ok ? tile_word_t'(q_b) : '0;
            px_x        <= ok ? px2 : '0;
            px_y        <= ok ? py2 : '0;
            bright_out  <= ok;
            hSync_out   <= hs2;
            vSync_out   <= vs2;
            frame_start <= fs2 && vld_pipe[STAGES-1];
        end
    end
endmodule
